// File: rtl/ps2_key_sequencer.sv
// PS/2 Set-2 scan-code sequencer: decodes E0/F0/E1 prefixes, tracks held
// game keys and emits single-cycle press-edge events.
module ps2_key_sequencer #(
    parameter int          PREFIX_TIMEOUT = 2500000,
    parameter logic [7:0]  KEY_SPACE      = 8'h29,
    parameter logic [7:0]  KEY_ENTER      = 8'h5A,
    parameter logic [7:0]  KEY_ESC        = 8'h76,
    parameter logic [7:0]  KEY_UP         = 8'h75
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    input  logic       code_err,
    output logic       space_down,
    output logic       up_down,
    output logic       enter_down,
    output logic       esc_down,
    output logic       flap_pulse,
    output logic       start_pulse,
    output logic       pause_pulse,
    output logic       seq_busy,
    output logic [7:0] err_count
);

    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 2;
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [TW-1:0] tmo_inc;
    logic [7:0]    err_q, err_d;
    logic          err_inc;
    logic          space_q, space_d;
    logic          up_q, up_d;
    logic          enter_q, enter_d;
    logic          esc_q, esc_d;
    logic          flap_q, flap_d;
    logic          start_q, start_d;
    logic          pause_q, pause_d;
    logic          space_edge, up_edge;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            space_q <= 1'b0;
            up_q    <= 1'b0;
            enter_q <= 1'b0;
            esc_q   <= 1'b0;
            flap_q  <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            space_q <= space_d;
            up_q    <= up_d;
            enter_q <= enter_d;
            esc_q   <= esc_d;
            flap_q  <= flap_d;
            start_q <= start_d;
            pause_q <= pause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        tmo_d      = tmo_q;
        tmo_inc    = tmo_q + 1'b1;
        err_inc    = 1'b0;
        space_d    = space_q;
        up_d       = up_q;
        enter_d    = enter_q;
        esc_d      = esc_q;
        space_edge = 1'b0;
        up_edge    = 1'b0;
        start_d    = 1'b0;
        pause_d    = 1'b0;

        if (code_valid && code_err) begin
            state_d = IDLE;
            skip_d  = '0;
            tmo_d   = '0;
            err_inc = 1'b1;
        end else if (code_valid) begin
            // A byte always restarts the prefix timer, even if one was due.
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    case (code_byte)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'hE1: begin
                            state_d = SKIP;
                            skip_d  = 3'd7;
                        end
                        8'h00, 8'hFF: begin
                            space_d = 1'b0;
                            up_d    = 1'b0;
                            enter_d = 1'b0;
                            esc_d   = 1'b0;
                            err_inc = 1'b1;
                        end
                        default: begin
                            if (code_byte == KEY_SPACE) begin
                                space_d    = 1'b1;
                                space_edge = !space_q;
                            end else if (code_byte == KEY_ENTER) begin
                                enter_d = 1'b1;
                                start_d = !enter_q;
                            end else if (code_byte == KEY_ESC) begin
                                esc_d   = 1'b1;
                                pause_d = !esc_q;
                            end
                        end
                    endcase
                end
                EXT: begin
                    state_d = IDLE;
                    if (code_byte == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (code_byte == KEY_UP) begin
                        up_d    = 1'b1;
                        up_edge = !up_q;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (code_byte == KEY_SPACE) begin
                        space_d = 1'b0;
                    end else if (code_byte == KEY_ENTER) begin
                        enter_d = 1'b0;
                    end else if (code_byte == KEY_ESC) begin
                        esc_d = 1'b0;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (code_byte == KEY_UP) begin
                        up_d = 1'b0;
                    end
                end
                SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_inc == TMO_LAST) begin
                state_d = IDLE;
                skip_d  = '0;
                tmo_d   = '0;
                err_inc = 1'b1;
            end else begin
                tmo_d = tmo_inc;
            end
        end

        flap_d = space_edge | up_edge;
        err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    assign space_down  = space_q;
    assign up_down     = up_q;
    assign enter_down  = enter_q;
    assign esc_down    = esc_q;
    assign flap_pulse  = flap_q;
    assign start_pulse = start_q;
    assign pause_pulse = pause_q;
    assign seq_busy    = (state_q != IDLE);
    assign err_count   = err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: expected output vectors are queued
// as each byte is driven and compared once the registered outputs update.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       code_valid;
    logic [7:0] code_byte;
    logic       code_err;
    logic       space_down, up_down, enter_down, esc_down;
    logic       flap_pulse, start_pulse, pause_pulse, seq_busy;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb_q[$];

    localparam logic [15:0] PULSE_MASK = 16'h0E00;

    ps2_key_sequencer #(.PREFIX_TIMEOUT(100)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .code_valid  (code_valid),
        .code_byte   (code_byte),
        .code_err    (code_err),
        .space_down  (space_down),
        .up_down     (up_down),
        .enter_down  (enter_down),
        .esc_down    (esc_down),
        .flap_pulse  (flap_pulse),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .seq_busy    (seq_busy),
        .err_count   (err_count)
    );

    always #10 clk = ~clk;

    // {space,up,enter,esc, flap,start,pause, busy, err_count}
    function automatic logic [15:0] mk(input logic [3:0] d, input logic [2:0] p,
                                       input logic b, input logic [7:0] e);
        return {d, p, b, e};
    endfunction

    function automatic logic [15:0] obs();
        return {space_down, up_down, enter_down, esc_down,
                flap_pulse, start_pulse, pause_pulse, seq_busy, err_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Strobe one byte, compare the following cycle, then confirm pulses fall.
    task automatic send(input string tag, input logic [7:0] b, input logic e,
                        input logic [15:0] exp);
        logic [15:0] want;
        @(negedge clk);
        code_valid = 1'b1;
        code_byte  = b;
        code_err   = e;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want = sb_q.pop_front();
            check(tag, 32'(obs()), 32'(want));
        end
        @(negedge clk);
        code_valid = 1'b0;
        code_err   = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_gap"}, 32'(obs()), 32'(exp & ~PULSE_MASK));
    endtask

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int n;

    initial begin
        resetn     = 1'b0;
        code_valid = 1'b0;
        code_byte  = 8'h00;
        code_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 32'(obs()), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // 1/2: press, typematic, release, press again
        send("sp_make", 8'h29, 1'b0, mk(4'b1000, 3'b100, 1'b0, 8'd0));
        send("sp_rep1", 8'h29, 1'b0, mk(4'b1000, 3'b000, 1'b0, 8'd0));
        send("sp_rep2", 8'h29, 1'b0, mk(4'b1000, 3'b000, 1'b0, 8'd0));
        send("sp_rep3", 8'h29, 1'b0, mk(4'b1000, 3'b000, 1'b0, 8'd0));
        send("brk_pre", 8'hF0, 1'b0, mk(4'b1000, 3'b000, 1'b1, 8'd0));
        send("sp_brk",  8'h29, 1'b0, mk(4'b0000, 3'b000, 1'b0, 8'd0));
        send("sp_mk2",  8'h29, 1'b0, mk(4'b1000, 3'b100, 1'b0, 8'd0));

        // 3: extended up arrow while space is held
        send("ext_pre", 8'hE0, 1'b0, mk(4'b1000, 3'b000, 1'b1, 8'd0));
        send("up_make", 8'h75, 1'b0, mk(4'b1100, 3'b100, 1'b0, 8'd0));
        send("bare_75", 8'h75, 1'b0, mk(4'b1100, 3'b000, 1'b0, 8'd0));
        send("eb_e0",   8'hE0, 1'b0, mk(4'b1100, 3'b000, 1'b1, 8'd0));
        send("eb_f0",   8'hF0, 1'b0, mk(4'b1100, 3'b000, 1'b1, 8'd0));
        send("up_brk",  8'h75, 1'b0, mk(4'b1000, 3'b000, 1'b0, 8'd0));
        send("e0_5a_p", 8'hE0, 1'b0, mk(4'b1000, 3'b000, 1'b1, 8'd0));
        send("e0_5a",   8'h5A, 1'b0, mk(4'b1000, 3'b000, 1'b0, 8'd0));

        // 4: pause sequence is swallowed whole
        for (int i = 0; i < 8; i++) begin
            send($sformatf("pause_b%0d", i), pause_seq[i], 1'b0,
                 mk(4'b1000, 3'b000, (i < 7), 8'd0));
        end
        send("esc_make", 8'h76, 1'b0, mk(4'b1001, 3'b001, 1'b0, 8'd0));
        send("ent_make", 8'h5A, 1'b0, mk(4'b1011, 3'b010, 1'b0, 8'd0));

        // 5: timeout, errors, saturation
        send("sp_rel_p", 8'hF0, 1'b0, mk(4'b1011, 3'b000, 1'b1, 8'd0));
        send("sp_rel",   8'h29, 1'b0, mk(4'b0011, 3'b000, 1'b0, 8'd0));

        @(negedge clk);
        code_valid = 1'b1;
        code_byte  = 8'hF0;
        @(posedge clk);
        #1;
        check("tmo_busy", 32'(seq_busy), 32'd1);
        @(negedge clk);
        code_valid = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!seq_busy) break;
        end
        check("tmo_cycles", 32'(n), 32'd99);
        check("tmo_err", 32'(obs()), 32'(mk(4'b0011, 3'b000, 1'b0, 8'd1)));

        send("post_tmo", 8'h29, 1'b0, mk(4'b1011, 3'b100, 1'b0, 8'd1));
        send("err_29",   8'h29, 1'b1, mk(4'b1011, 3'b000, 1'b0, 8'd2));

        @(negedge clk);
        code_err = 1'b1;
        @(posedge clk);
        #1;
        check("err_noval", 32'(err_count), 32'd2);
        @(negedge clk);
        code_err = 1'b0;

        send("err_ext_p", 8'hE0, 1'b0, mk(4'b1011, 3'b000, 1'b1, 8'd2));
        send("err_ext",   8'h75, 1'b1, mk(4'b1011, 3'b000, 1'b0, 8'd3));

        // Byte lands on the very cycle the timeout would have fired.
        send("race_pre", 8'hF0, 1'b0, mk(4'b1011, 3'b000, 1'b1, 8'd3));
        repeat (97) @(posedge clk);
        send("race_brk", 8'h29, 1'b0, mk(4'b0011, 3'b000, 1'b0, 8'd3));

        send("overrun", 8'h00, 1'b0, mk(4'b0000, 3'b000, 1'b0, 8'd4));

        for (int i = 0; i < 299; i++) begin
            @(negedge clk);
            code_valid = 1'b1;
            code_err   = 1'b1;
            code_byte  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        code_valid = 1'b0;
        code_err   = 1'b0;
        send("err_sat", 8'h29, 1'b1, mk(4'b0000, 3'b000, 1'b0, 8'd255));

        // 6: reset lands on the second byte of E0 75
        send("rst_pre", 8'hE0, 1'b0, mk(4'b0000, 3'b000, 1'b1, 8'd255));
        @(negedge clk);
        code_valid = 1'b1;
        code_byte  = 8'h75;
        resetn     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid", 32'(obs()), 32'd0);
        @(negedge clk);
        code_valid = 1'b0;
        resetn     = 1'b1;
        send("rst_75", 8'h75, 1'b0, mk(4'b0000, 3'b000, 1'b0, 8'd0));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
